px_diff_scan_ctrl: RTL and testbench
====================================

// Module: px_diff_scan_ctrl
// PURPOSE
//  Frame-difference scan controller for motion detection.
//  - Walks current-frame and reference-frame pixel buffers (RGB332, shared address) once per start.
//  - Aligns read data to BRAM latency and feeds each pixel pair to euclid_px_diff.
//  - Accumulates total difference and the count of pixels whose difference exceeds a threshold.
//  - Raises a motion flag; used by the frame-capture top level between VGA frames.
// PARAMETERS
//  NUM_PX     19200  pixels per frame (160x120), >=2
//  ADDR_W     15     read-address width, 2**ADDR_W >= NUM_PX
//  RD_LAT     2      buffer read latency in cycles, 1..4
//  SUM_W      20     width of frame_sum, saturating
//  CNT_W      15     width of chg_cnt, saturating
// PORTS
//  clk        in   1       system clock; the only clock
//  rst        in   1       synchronous, active-high reset
//  start      in   1       one-cycle pulse; begins a scan when idle
//  abort      in   1       stops the scan, returns to IDLE, no done
//  px_thresh  in   5       per-pixel change threshold (diff > px_thresh counts)
//  motion_min in   CNT_W   changed-pixel count at which motion is declared
//  rd_en      out  1       read strobe to both pixel buffers
//  rd_addr    out  ADDR_W  shared read address
//  px_cur     in   8       current-frame pixel, valid RD_LAT cycles after rd_en
//  px_ref     in   8       reference-frame pixel, same timing as px_cur
//  busy       out  1       high from the cycle after start until done
//  done       out  1       one-cycle pulse when results are final
//  frame_sum  out  SUM_W   sum of per-pixel differences
//  chg_cnt    out  CNT_W   pixels with diff > px_thresh
//  motion     out  1       chg_cnt >= motion_min, updated with done
// BEHAVIOUR
//  - Reset: state=IDLE; rd_en, busy, done, motion = 0; rd_addr, frame_sum, chg_cnt = 0; valid pipe cleared.
//  - FSM: IDLE -> SCAN -> DRAIN -> DONE -> IDLE.
//    - IDLE: start=1 -> SCAN; clear frame_sum and chg_cnt; rd_addr=0.
//    - SCAN: rd_en=1 for exactly NUM_PX cycles, rd_addr 0..NUM_PX-1, +1 per cycle.
//      After issuing NUM_PX-1 -> DRAIN; rd_addr returns to 0, no wrap past NUM_PX-1.
//    - DRAIN: rd_en=0 for RD_LAT+1 cycles (pipe empties, last accumulate registers) -> DONE.
//    - DONE: done=1 for one cycle; motion registered; -> IDLE.
//  - Data alignment:
//    - rd_en is delayed through an RD_LAT-deep valid shift register.
//    - When the delayed valid=1, sample px_cur/px_ref and compute diff = euclid_px_diff(px_cur, px_ref).
//    - diff range is 0..17, zero-extended.
//  - Accumulate, on each valid cycle:
//    - frame_sum += diff, saturating at all-ones.
//    - chg_cnt += (diff > px_thresh), saturating at all-ones.
//  - Timing: start sampled at cycle T -> first rd_en at T+1 -> done at T+NUM_PX+RD_LAT+2.
//  - busy is high from T+1 through the done cycle inclusive; busy=0 in IDLE.
//  - Results (frame_sum, chg_cnt, motion) hold their last value in IDLE until the next accepted start.
//  - frame_sum and chg_cnt update live during SCAN/DRAIN; they are final only at done.
//  - start while busy is ignored; no queuing.
//  - start in the DONE cycle is ignored.
//  - abort in SCAN/DRAIN: the next state is IDLE.
//    - rd_en=0 next cycle; the valid pipe is flushed.
//    - done stays 0; motion is not updated; partial sums are left visible.
//  - abort and start in the same IDLE cycle: abort wins, no scan.
//  - abort in DONE has no effect; done still pulses.
//  - px_thresh and motion_min are sampled on start and held in internal registers for the scan.
//  - rst mid-scan: immediate return to reset values on the next edge; buffers are not affected.
// STRUCTURE
//  - Shared package/header px_pkg: RGB332 field widths and positions (R[7:5], G[4:2], B[1:0]).
//    It also holds the state encoding localparams: S_IDLE, S_SCAN, S_DRAIN, S_DONE.
//  - One sub-module: euclid_px_diff (combinational), instantiated once, driven by the aligned pixel pair.
//  - Everything else is in this module: FSM, address counter, valid pipe, accumulators.
// TESTING (NUM_PX=16, RD_LAT=2, SUM_W=8, CNT_W=5 unless noted; buffer models have 2-cycle latency)
//  1. Identical frames, thresh=0, min=1, start -> done at T+20; sum=0, cnt=0, motion=0; rd_addr 0..15 once.
//  2. ref=0x00, cur=0xFF everywhere (diff 17), thresh=16, min=16 -> sum=255 (saturated from 272), cnt=16, motion=1.
//  3. One pixel at addr 7, cur=0xE0 vs ref=0x00 (diff 7), thresh=6 -> sum=7, cnt=1; rerun with thresh=7 -> cnt=0.
//  4. Second start pulse mid-SCAN and another in the DONE cycle -> ignored; exactly one done pulse; no extra rd_en.
//  5. abort at SCAN cycle 5 -> IDLE next cycle, rd_en low, no done; fresh start then gives case-1 results.
//  6. rst at SCAN cycle 9 -> all outputs 0 next cycle; RD_LAT=4 rerun of case 2 -> done at T+22, same sums.

Source files
------------

// File: rtl/px_pkg.sv
// Shared definitions for the frame-difference scanner: RGB332 field layout,
// difference width, scan FSM state encoding and a small field helper.
package px_pkg;

    localparam int R_W    = 3;
    localparam int G_W    = 3;
    localparam int B_W    = 2;
    localparam int R_LSB  = 5;
    localparam int G_LSB  = 2;
    localparam int B_LSB  = 0;
    localparam int DIFF_W = 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    function automatic logic [2:0] abs_sub3(input logic [2:0] a, input logic [2:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/euclid_px_diff.sv
// Combinational RGB332 pixel distance: sum of per-channel absolute differences,
// giving 0..17 (7 + 7 + 3).
module euclid_px_diff
    import px_pkg::*;
(
    input  logic [7:0]        px_a_i,
    input  logic [7:0]        px_b_i,
    output logic [DIFF_W-1:0] diff_o
);

    logic [2:0] dr;
    logic [2:0] dg;
    logic [2:0] db;

    assign dr = abs_sub3(px_a_i[R_LSB +: R_W], px_b_i[R_LSB +: R_W]);
    assign dg = abs_sub3(px_a_i[G_LSB +: G_W], px_b_i[G_LSB +: G_W]);
    assign db = abs_sub3({1'b0, px_a_i[B_LSB +: B_W]}, {1'b0, px_b_i[B_LSB +: B_W]});

    assign diff_o = DIFF_W'(dr) + DIFF_W'(dg) + DIFF_W'(db);

endmodule

// File: rtl/px_diff_scan_ctrl.sv
// Frame-difference scan controller: walks both pixel buffers once per start,
// accumulates saturating difference sum and changed-pixel count, flags motion.
module px_diff_scan_ctrl
    import px_pkg::*;
#(
    parameter int NUM_PX = 19200,
    parameter int ADDR_W = 15,
    parameter int RD_LAT = 2,
    parameter int SUM_W  = 20,
    parameter int CNT_W  = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [4:0]        px_thresh,
    input  logic [CNT_W-1:0]  motion_min,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        px_cur,
    input  logic [7:0]        px_ref,
    output logic              busy,
    output logic              done,
    output logic [SUM_W-1:0]  frame_sum,
    output logic [CNT_W-1:0]  chg_cnt,
    output logic              motion
);

    function automatic logic [SUM_W-1:0] sat_add_sum(input logic [SUM_W-1:0] a,
                                                     input logic [DIFF_W-1:0] b);
        logic [SUM_W:0] s;
        s = {1'b0, a} + (SUM_W + 1)'(b);
        return s[SUM_W] ? '1 : s[SUM_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] a,
                                                     input logic inc);
        if (!inc || (a == '1))
            return a;
        return a + CNT_W'(1);
    endfunction

    state_e             state_q;
    logic               rd_en_q;
    logic [ADDR_W-1:0]  rd_addr_q;
    logic               busy_q;
    logic               done_q;
    logic               motion_q;
    logic [SUM_W-1:0]   sum_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [RD_LAT-1:0]  vld_q;
    logic [4:0]         thresh_q;
    logic [CNT_W-1:0]   min_q;
    logic [2:0]         drain_q;

    logic [DIFF_W-1:0]  diff;
    logic               px_vld;
    logic [SUM_W-1:0]   sum_d;
    logic [CNT_W-1:0]   cnt_d;

    euclid_px_diff u_diff (
        .px_a_i (px_cur),
        .px_b_i (px_ref),
        .diff_o (diff)
    );

    assign px_vld = vld_q[RD_LAT-1];
    assign sum_d  = sat_add_sum(sum_q, diff);
    assign cnt_d  = sat_inc_cnt(cnt_q, diff > thresh_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            motion_q  <= 1'b0;
            sum_q     <= '0;
            cnt_q     <= '0;
            vld_q     <= '0;
            thresh_q  <= '0;
            min_q     <= '0;
            drain_q   <= '0;
        end else begin
            // rd_en delayed by RD_LAT marks the cycle the buffers present data
            vld_q[0] <= rd_en_q;
            for (int i = 1; i < RD_LAT; i++)
                vld_q[i] <= vld_q[i-1];

            done_q <= 1'b0;
            if (px_vld) begin
                sum_q <= sum_d;
                cnt_q <= cnt_d;
            end

            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        state_q   <= S_SCAN;
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= '0;
                        busy_q    <= 1'b1;
                        sum_q     <= '0;
                        cnt_q     <= '0;
                        thresh_q  <= px_thresh;
                        min_q     <= motion_min;
                    end
                end
                S_SCAN: begin
                    if (abort) begin
                        state_q   <= S_IDLE;
                        rd_en_q   <= 1'b0;
                        rd_addr_q <= '0;
                        busy_q    <= 1'b0;
                        vld_q     <= '0;
                    end else if (rd_addr_q == ADDR_W'(NUM_PX - 1)) begin
                        state_q   <= S_DRAIN;
                        rd_en_q   <= 1'b0;
                        rd_addr_q <= '0;
                        drain_q   <= '0;
                    end else begin
                        rd_addr_q <= rd_addr_q + ADDR_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        vld_q   <= '0;
                    end else if (drain_q == 3'(RD_LAT)) begin
                        // last accumulate has landed; count is final here
                        state_q  <= S_DONE;
                        done_q   <= 1'b1;
                        motion_q <= (cnt_q >= min_q);
                    end else begin
                        drain_q <= drain_q + 3'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    rd_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_sum = sum_q;
    assign chg_cnt   = cnt_q;
    assign motion    = motion_q;

endmodule

// File: tb/tb_px_diff_scan_ctrl.sv
// Scoreboard bench for px_diff_scan_ctrl: RD_LAT=2 and RD_LAT=4 instances with
// latency-matched buffer models and hand-computed expected results.
module tb_px_diff_scan_ctrl;

    typedef struct {
        int cyc;
        int sum;
        int cnt;
        int mot;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    exp_t exp_qa[$];
    exp_t exp_qb[$];
    int   addr_qa[$];

    logic [7:0] cur_mem [16];
    logic [7:0] ref_mem [16];

    logic        rst_a = 1'b1, rst_b = 1'b1;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic        abort = 1'b0, abort_b = 1'b0;
    logic [4:0]  thresh = '0;
    logic [4:0]  mmin = '0;

    logic        rd_en_a, busy_a, done_a, mot_a;
    logic [14:0] rd_addr_a;
    logic [7:0]  cur_a, ref_a;
    logic [7:0]  sum_a;
    logic [4:0]  cnt_a;

    logic        rd_en_b, busy_b, done_b, mot_b;
    logic [14:0] rd_addr_b;
    logic [7:0]  cur_b, ref_b;
    logic [7:0]  sum_b;
    logic [4:0]  cnt_b;

    px_diff_scan_ctrl #(.NUM_PX(16), .ADDR_W(15), .RD_LAT(2), .SUM_W(8), .CNT_W(5)) dut_a (
        .clk(clk), .rst(rst_a), .start(start_a), .abort(abort),
        .px_thresh(thresh), .motion_min(mmin),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .px_cur(cur_a), .px_ref(ref_a),
        .busy(busy_a), .done(done_a), .frame_sum(sum_a), .chg_cnt(cnt_a), .motion(mot_a)
    );

    px_diff_scan_ctrl #(.NUM_PX(16), .ADDR_W(15), .RD_LAT(4), .SUM_W(8), .CNT_W(5)) dut_b (
        .clk(clk), .rst(rst_b), .start(start_b), .abort(abort_b),
        .px_thresh(thresh), .motion_min(mmin),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .px_cur(cur_b), .px_ref(ref_b),
        .busy(busy_b), .done(done_b), .frame_sum(sum_b), .chg_cnt(cnt_b), .motion(mot_b)
    );

    // Buffer models: 2-cycle latency for dut_a, 4-cycle for dut_b
    logic [7:0] ca [2];
    logic [7:0] ra [2];
    logic [7:0] cb [4];
    logic [7:0] rb [4];
    always @(posedge clk) begin
        ca[0] <= cur_mem[rd_addr_a[3:0]];
        ra[0] <= ref_mem[rd_addr_a[3:0]];
        ca[1] <= ca[0];
        ra[1] <= ra[0];
        cb[0] <= cur_mem[rd_addr_b[3:0]];
        rb[0] <= ref_mem[rd_addr_b[3:0]];
        for (int i = 1; i < 4; i++) begin
            cb[i] <= cb[i-1];
            rb[i] <= rb[i-1];
        end
    end
    assign cur_a = ca[1];
    assign ref_a = ra[1];
    assign cur_b = cb[3];
    assign ref_b = rb[3];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: pop expectations when the DUT presents rd_en or done
    always @(negedge clk) begin
        if (!rst_a) begin
            if (rd_en_a) begin
                if (addr_qa.size() == 0)
                    check("a_unexpected_rd_en", 1, 0);
                else
                    check("a_rd_addr", int'(rd_addr_a), addr_qa.pop_front());
            end
            if (done_a) begin
                if (exp_qa.size() == 0) begin
                    check("a_unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_qa.pop_front();
                    check("a_done_cycle", cyc, e.cyc);
                    check("a_frame_sum", int'(sum_a), e.sum);
                    check("a_chg_cnt", int'(cnt_a), e.cnt);
                    check("a_motion", int'(mot_a), e.mot);
                    check("a_busy_at_done", int'(busy_a), 1);
                end
            end
        end
        if (!rst_b && done_b) begin
            if (exp_qb.size() == 0) begin
                check("b_unexpected_done", 1, 0);
            end else begin
                exp_t e;
                e = exp_qb.pop_front();
                check("b_done_cycle", cyc, e.cyc);
                check("b_frame_sum", int'(sum_b), e.sum);
                check("b_chg_cnt", int'(cnt_b), e.cnt);
                check("b_motion", int'(mot_b), e.mot);
            end
        end
    end

    task automatic goto_cyc(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic fill(input logic [7:0] cv, input logic [7:0] rv);
        for (int i = 0; i < 16; i++) begin
            cur_mem[i] = cv;
            ref_mem[i] = rv;
        end
    endtask

    task automatic run_a(input logic [4:0] th, input logic [4:0] mn, input bit exp_done,
                         input int s, input int c, input int m, output int t0);
        exp_t e;
        @(posedge clk);
        #1;
        thresh  = th;
        mmin    = mn;
        start_a = 1'b1;
        t0      = cyc;
        if (exp_done) begin
            e.cyc = t0 + 20; e.sum = s; e.cnt = c; e.mot = m;
            exp_qa.push_back(e);
        end
        for (int i = 0; i < 16; i++) addr_qa.push_back(i);
        @(posedge clk);
        #1;
        start_a = 1'b0;
    endtask

    task automatic wait_a(input string name);
        for (int i = 0; i < 100 && exp_qa.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check({name, "_done_seen"}, exp_qa.size(), 0);
        check({name, "_rd_count"}, addr_qa.size(), 0);
        exp_qa.delete();
        addr_qa.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int t0;
        exp_t e;
        fill(8'h00, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        check("rst_busy", int'(busy_a), 0);
        check("rst_done", int'(done_a), 0);
        check("rst_rd_en", int'(rd_en_a), 0);
        check("rst_rd_addr", int'(rd_addr_a), 0);
        check("rst_sum", int'(sum_a), 0);
        check("rst_cnt", int'(cnt_a), 0);
        check("rst_motion", int'(mot_a), 0);

        // Identical frames
        fill(8'h5A, 8'h5A);
        run_a(5'd0, 5'd1, 1'b1, 0, 0, 0, t0);
        check("c1_busy_after_start", int'(busy_a), 1);
        wait_a("c1");
        check("c1_idle_busy", int'(busy_a), 0);

        // Full-scale difference, saturating sum
        fill(8'hFF, 8'h00);
        run_a(5'd16, 5'd16, 1'b1, 255, 16, 1, t0);
        wait_a("c2");
        check("c2_hold_sum", int'(sum_a), 255);
        check("c2_hold_motion", int'(mot_a), 1);

        // Single changed pixel, threshold just below and at its diff
        fill(8'h00, 8'h00);
        cur_mem[7] = 8'hE0;
        run_a(5'd6, 5'd1, 1'b1, 7, 1, 1, t0);
        wait_a("c3a");
        run_a(5'd7, 5'd1, 1'b1, 7, 0, 0, t0);
        wait_a("c3b");

        // Start while busy and start in the DONE cycle are ignored
        fill(8'h5A, 8'h5A);
        run_a(5'd0, 5'd1, 1'b1, 0, 0, 0, t0);
        goto_cyc(t0 + 8);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        goto_cyc(t0 + 20);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        check("c4_busy_after_done", int'(busy_a), 0);
        check("c4_rd_en_after_done", int'(rd_en_a), 0);
        wait_a("c4");

        // Abort in SCAN cycle 5
        run_a(5'd0, 5'd1, 1'b0, 0, 0, 0, t0);
        goto_cyc(t0 + 5);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("c5_abort_rd_en", int'(rd_en_a), 0);
        check("c5_abort_busy", int'(busy_a), 0);
        check("c5_addrs_issued", 16 - addr_qa.size(), 5);
        addr_qa.delete();
        repeat (30) @(posedge clk);
        #1;
        start_a = 1'b1;
        abort   = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        abort   = 1'b0;
        check("c5_abort_wins_busy", int'(busy_a), 0);
        check("c5_abort_wins_rd_en", int'(rd_en_a), 0);
        run_a(5'd0, 5'd1, 1'b1, 0, 0, 0, t0);
        wait_a("c5");

        // Reset mid-scan, then the RD_LAT=4 instance repeats the full-scale case
        fill(8'hFF, 8'h00);
        run_a(5'd16, 5'd16, 1'b0, 0, 0, 0, t0);
        goto_cyc(t0 + 9);
        rst_a = 1'b1;
        @(posedge clk);
        #1;
        check("c6_rst_rd_en", int'(rd_en_a), 0);
        check("c6_rst_busy", int'(busy_a), 0);
        check("c6_rst_rd_addr", int'(rd_addr_a), 0);
        check("c6_rst_sum", int'(sum_a), 0);
        check("c6_rst_cnt", int'(cnt_a), 0);
        check("c6_rst_motion", int'(mot_a), 0);
        rst_a = 1'b0;
        addr_qa.delete();
        repeat (30) @(posedge clk);
        #1;

        thresh  = 5'd16;
        mmin    = 5'd16;
        start_b = 1'b1;
        t0      = cyc;
        e.cyc = t0 + 22; e.sum = 255; e.cnt = 16; e.mot = 1;
        exp_qb.push_back(e);
        @(posedge clk);
        #1;
        start_b = 1'b0;
        for (int i = 0; i < 100 && exp_qb.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("c6_b_done_seen", exp_qb.size(), 0);
        repeat (3) @(posedge clk);
        #1;
        check("c6_b_idle_busy", int'(busy_b), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
